imem_port_arbiter: RTL and testbench
====================================

// Module: imem_port_arbiter
// PURPOSE
//  Shares the single-port instruction ROM (10-bit word address, 32-bit data) between the CPU
//  fetch port and a debug/trace read port. Fixed fetch priority with a starvation guard for
//  debug; read data is registered, so each port sees rvalid one cycle after its grant.
//  Sits between the PC/fetch stage, the debug reader and the ROM.
// PARAMETERS
//  ADDR_W      10  ROM word-address width
//  DATA_W      32  ROM data width
//  STARVE_MAX  4   consecutive denied debug cycles before debug is forced a grant (1..15)
// PORTS
//  clk         in   1       system clock, rising edge
//  rst         in   1       synchronous reset, active-high
//  f_req       in   1       fetch request; held until f_gnt
//  f_addr      in   ADDR_W  fetch word address; stable while f_req high
//  f_gnt       out  1       fetch granted this cycle (combinational)
//  f_rvalid    out  1       f_rdata valid (registered)
//  f_rdata     out  DATA_W  fetch read data
//  d_req       in   1       debug request; held until d_gnt
//  d_addr      in   ADDR_W  debug word address; stable while d_req high
//  d_gnt       out  1       debug granted this cycle (combinational)
//  d_rvalid    out  1       d_rdata valid (registered)
//  d_rdata     out  DATA_W  debug read data
//  rom_addr    out  ADDR_W  address to ROM
//  rom_data    in   DATA_W  ROM data, combinational from rom_addr
//  starve_cnt  out  4       debug wait counter (observability)
// BEHAVIOUR
//  Reset: f_rvalid=d_rvalid=0, f_rdata=d_rdata=0, starve_cnt=0, state=FETCH_PRI, rom_addr=0.
//  States: FETCH_PRI (default), DEBUG_FORCE.
//   FETCH_PRI: f_req -> f_gnt; else d_req -> d_gnt. If d_req && f_req, starve_cnt+1;
//     when starve_cnt reaches STARVE_MAX-1 with debug still denied -> DEBUG_FORCE.
//   DEBUG_FORCE: d_gnt=1 (f_gnt=0 even if f_req) for exactly one cycle -> FETCH_PRI.
//     If d_req dropped (protocol violation) no grant is issued; return to FETCH_PRI.
//  starve_cnt clears on any d_gnt or when d_req=0; saturates at STARVE_MAX-1.
//  At most one of f_gnt/d_gnt high per cycle; gnt never high without matching req.
//  rom_addr = granted port's address; no grant -> hold last rom_addr.
//  Latency: grant in cycle N -> rvalid=1 and rdata=rom_data(addr) in cycle N+1, 1 cycle wide.
//  Back-to-back grants to one port -> rvalid stays high; rdata updates every cycle.
//  rdata holds its last value when rvalid=0 (not cleared).
//  Addresses beyond program length return ROM default (0); no range check here.
//  rst mid-operation: pending rvalid is dropped, counter/state cleared next edge; requesters
//  re-issue after reset.
// STRUCTURE
//  Shared package imem_pkg: ADDR_W/DATA_W defaults, state encodings ST_FETCH_PRI=1'b0,
//  ST_DEBUG_FORCE=1'b1. Single module, no sub-modules; ROM instantiated one level up.
// TESTING
//  1 f_req only, f_addr 0..3 consecutive -> f_gnt every cycle; f_rdata next cycle =
//    32'h03000713, 32'h00000593, 32'h02200513, 32'h00000073; f_rvalid high 4 cycles.
//  2 d_req only, d_addr=10'd13 -> d_gnt same cycle; next cycle d_rvalid=1,
//    d_rdata=32'hfc000ee3; f_rvalid stays 0.
//  3 f_req and d_req held, STARVE_MAX=4 -> f_gnt 4 cycles, starve_cnt 1,2,3,3; 5th cycle
//    d_gnt=1, f_gnt=0; then f_gnt resumes, starve_cnt=0.
//  4 d_req dropped while in DEBUG_FORCE -> no grant that cycle, state back to FETCH_PRI.
//  5 rst asserted cycle after grant (d_addr=10'd2) -> d_rvalid=0 after edge, starve_cnt=0,
//    rom_addr=0.
//  6 d_addr=10'd1000 (past program end) -> d_rdata=32'h0, d_rvalid=1.

Source files
------------

// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-ROM port arbiter: default widths,
// the starvation limit and the arbiter state encodings.
package imem_pkg;

    localparam int ADDR_W_DEF     = 10;
    localparam int DATA_W_DEF     = 32;
    localparam int STARVE_MAX_DEF = 4;

    typedef enum logic {
        ST_FETCH_PRI   = 1'b0,
        ST_DEBUG_FORCE = 1'b1
    } arb_state_e;

endpackage

// File: rtl/imem_port_arbiter.sv
// Shares one single-port instruction ROM between the CPU fetch port and a debug/trace
// read port. Fetch has fixed priority. A starvation guard forces an occasional debug grant.
//
//  state          | meaning
//  ---------------+----------------------------------------------------------
//  ST_FETCH_PRI   | fetch wins; a denied debug request advances starve_cnt
//  ST_DEBUG_FORCE | one-cycle slot reserved for debug; fetch is held off
module imem_port_arbiter
    import imem_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_gnt,
    output logic              f_rvalid,
    output logic [DATA_W-1:0] f_rdata,
    input  logic              d_req,
    input  logic [ADDR_W-1:0] d_addr,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic [3:0]        starve_cnt
);

    localparam logic [3:0] CNT_MAX = 4'(STARVE_MAX - 1);

    arb_state_e        state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] rom_addr_q;
    logic              f_rvalid_q, f_rvalid_d;
    logic              d_rvalid_q, d_rvalid_d;
    logic [DATA_W-1:0] f_rdata_q, f_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        f_gnt   = 1'b0;
        d_gnt   = 1'b0;
        // No grants while reset is applied, so nothing is launched into a clearing pipeline.
        if (!rst) begin
            unique case (state_q)
                ST_FETCH_PRI: begin
                    if (f_req) begin
                        f_gnt = 1'b1;
                    end else if (d_req) begin
                        d_gnt = 1'b1;
                    end
                    if (f_req && d_req) begin
                        if (cnt_q == CNT_MAX) begin
                            state_d = ST_DEBUG_FORCE;
                        end else begin
                            cnt_d = cnt_q + 4'd1;
                        end
                    end else begin
                        cnt_d = 4'd0;
                    end
                end
                ST_DEBUG_FORCE: begin
                    d_gnt   = d_req;
                    cnt_d   = 4'd0;
                    state_d = ST_FETCH_PRI;
                end
                default: begin
                    state_d = ST_FETCH_PRI;
                    cnt_d   = 4'd0;
                end
            endcase
        end
    end

    always_comb begin
        if (f_gnt) begin
            rom_addr = f_addr;
        end else if (d_gnt) begin
            rom_addr = d_addr;
        end else begin
            rom_addr = rom_addr_q;
        end
        f_rvalid_d = f_gnt;
        d_rvalid_d = d_gnt;
        f_rdata_d  = f_gnt ? rom_data : f_rdata_q;
        d_rdata_d  = d_gnt ? rom_data : d_rdata_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_FETCH_PRI;
            cnt_q      <= 4'd0;
            rom_addr_q <= '0;
            f_rvalid_q <= 1'b0;
            d_rvalid_q <= 1'b0;
            f_rdata_q  <= '0;
            d_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rom_addr_q <= rom_addr;
            f_rvalid_q <= f_rvalid_d;
            d_rvalid_q <= d_rvalid_d;
            f_rdata_q  <= f_rdata_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

    assign f_rvalid   = f_rvalid_q;
    assign d_rvalid   = d_rvalid_q;
    assign f_rdata    = f_rdata_q;
    assign d_rdata    = d_rdata_q;
    assign starve_cnt = cnt_q;

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Self-checking bench for imem_port_arbiter: directed scenarios with fixed expected
// values, then randomized traffic against a cycle-level behavioural model.
module tb_imem_port_arbiter;

    localparam int SM = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        f_req, d_req;
    logic [9:0]  f_addr, d_addr;
    logic        f_gnt, d_gnt, f_rvalid, d_rvalid;
    logic [31:0] f_rdata, d_rdata, rom_data;
    logic [9:0]  rom_addr;
    logic [3:0]  starve_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_fn(input logic [9:0] a);
        case (a)
            10'd0:   return 32'h03000713;
            10'd1:   return 32'h00000593;
            10'd2:   return 32'h02200513;
            10'd3:   return 32'h00000073;
            10'd4:   return 32'h00a00613;
            10'd5:   return 32'h00c58633;
            10'd6:   return 32'h00b50533;
            10'd7:   return 32'hfff60613;
            10'd8:   return 32'hfe061ce3;
            10'd9:   return 32'h00100073;
            10'd10:  return 32'h0000006f;
            10'd11:  return 32'h12345678;
            10'd12:  return 32'h0aa00593;
            10'd13:  return 32'hfc000ee3;
            10'd14:  return 32'h00008067;
            10'd15:  return 32'hdeadbeef;
            default: return 32'h0;
        endcase
    endfunction

    assign rom_data = rom_fn(rom_addr);

    imem_port_arbiter #(.ADDR_W(10), .DATA_W(32), .STARVE_MAX(SM)) dut (
        .clk(clk), .rst(rst),
        .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid), .f_rdata(f_rdata),
        .d_req(d_req), .d_addr(d_addr), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .rom_addr(rom_addr), .rom_data(rom_data), .starve_cnt(starve_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; f_req = 1'b0; d_req = 1'b0; f_addr = '0; d_addr = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; f_req = 1'b0; d_req = 1'b0; f_addr = 10'd9; d_addr = 10'd9;
        tick();
        tick();
        checks++;
        if (f_rvalid !== 1'b0 || d_rvalid !== 1'b0 || f_rdata !== 32'h0 || d_rdata !== 32'h0 ||
            starve_cnt !== 4'd0 || rom_addr !== 10'd0) begin
            errors++;
            $display("FAIL reset: frv %b drv %b frd %h drd %h cnt %0d ra %0d, required all zero",
                     f_rvalid, d_rvalid, f_rdata, d_rdata, starve_cnt, rom_addr);
        end
        rst = 1'b0;
    endtask

    task automatic test_fetch_seq();
        logic [31:0] exp_f [4];
        exp_f = '{32'h03000713, 32'h00000593, 32'h02200513, 32'h00000073};
        for (int i = 0; i < 4; i++) begin
            f_req = 1'b1; f_addr = 10'(i);
            #2;
            checks++;
            if (f_gnt !== 1'b1 || d_gnt !== 1'b0) begin
                errors++;
                $display("FAIL fetch_gnt[%0d]: f_gnt %b d_gnt %b, required 1 0", i, f_gnt, d_gnt);
            end
            tick();
            checks++;
            if (f_rvalid !== 1'b1 || f_rdata !== exp_f[i] || d_rvalid !== 1'b0) begin
                errors++;
                $display("FAIL fetch_data[%0d]: frv %b frd %h drv %b, required 1 %h 0",
                         i, f_rvalid, f_rdata, d_rvalid, exp_f[i]);
            end
        end
        f_req = 1'b0;
        tick();
        checks++;
        if (f_rvalid !== 1'b0 || f_rdata !== 32'h00000073) begin
            errors++;
            $display("FAIL fetch_hold: frv %b frd %h, required 0 00000073", f_rvalid, f_rdata);
        end
    endtask

    task automatic test_debug_single();
        d_req = 1'b1; d_addr = 10'd13;
        #2;
        checks++;
        if (d_gnt !== 1'b1 || f_gnt !== 1'b0 || rom_addr !== 10'd13) begin
            errors++;
            $display("FAIL dbg_gnt: d_gnt %b f_gnt %b ra %0d, required 1 0 13", d_gnt, f_gnt, rom_addr);
        end
        tick();
        d_req = 1'b0;
        checks++;
        if (d_rvalid !== 1'b1 || d_rdata !== 32'hfc000ee3 || f_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL dbg_data: drv %b drd %h frv %b, required 1 fc000ee3 0", d_rvalid, d_rdata, f_rvalid);
        end
        #2;
        checks++;
        if (rom_addr !== 10'd13 || d_gnt !== 1'b0) begin
            errors++;
            $display("FAIL dbg_addr_hold: ra %0d d_gnt %b, required 13 0", rom_addr, d_gnt);
        end
        tick();
        checks++;
        if (d_rvalid !== 1'b0 || d_rdata !== 32'hfc000ee3) begin
            errors++;
            $display("FAIL dbg_hold: drv %b drd %h, required 0 fc000ee3", d_rvalid, d_rdata);
        end
    endtask

    // Builds four denied debug cycles; returns with the arbiter owing debug a slot.
    task automatic starve_four();
        logic [3:0] exp_c [4];
        exp_c = '{4'd1, 4'd2, 4'd3, 4'd3};
        f_req = 1'b1; f_addr = 10'd5; d_req = 1'b1; d_addr = 10'd7;
        for (int i = 0; i < 4; i++) begin
            #2;
            checks++;
            if (f_gnt !== 1'b1 || d_gnt !== 1'b0) begin
                errors++;
                $display("FAIL starve_gnt[%0d]: f_gnt %b d_gnt %b, required 1 0", i, f_gnt, d_gnt);
            end
            tick();
            checks++;
            if (starve_cnt !== exp_c[i]) begin
                errors++;
                $display("FAIL starve_cnt[%0d]: got %0d, required %0d", i, starve_cnt, exp_c[i]);
            end
        end
    endtask

    task automatic test_starvation();
        do_reset();
        starve_four();
        #2;
        checks++;
        if (d_gnt !== 1'b1 || f_gnt !== 1'b0 || rom_addr !== 10'd7) begin
            errors++;
            $display("FAIL force_gnt: d_gnt %b f_gnt %b ra %0d, required 1 0 7", d_gnt, f_gnt, rom_addr);
        end
        tick();
        d_req = 1'b0;
        checks++;
        if (starve_cnt !== 4'd0 || d_rvalid !== 1'b1 || d_rdata !== 32'hfff60613 || f_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL force_data: cnt %0d drv %b drd %h frv %b, required 0 1 fff60613 0",
                     starve_cnt, d_rvalid, d_rdata, f_rvalid);
        end
        #2;
        checks++;
        if (f_gnt !== 1'b1 || d_gnt !== 1'b0) begin
            errors++;
            $display("FAIL force_resume: f_gnt %b d_gnt %b, required 1 0", f_gnt, d_gnt);
        end
        tick();
        f_req = 1'b0;
        tick();
    endtask

    task automatic test_force_drop();
        do_reset();
        starve_four();
        d_req = 1'b0;
        #2;
        checks++;
        if (d_gnt !== 1'b0 || f_gnt !== 1'b0 || rom_addr !== 10'd5) begin
            errors++;
            $display("FAIL drop_nogrant: d_gnt %b f_gnt %b ra %0d, required 0 0 5", d_gnt, f_gnt, rom_addr);
        end
        tick();
        checks++;
        if (starve_cnt !== 4'd0 || d_rvalid !== 1'b0 || f_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL drop_after: cnt %0d drv %b frv %b, required 0 0 0", starve_cnt, d_rvalid, f_rvalid);
        end
        #2;
        checks++;
        if (f_gnt !== 1'b1) begin
            errors++;
            $display("FAIL drop_resume: f_gnt %b, required 1", f_gnt);
        end
        tick();
        f_req = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        f_req = 1'b1; f_addr = 10'd1; d_req = 1'b1; d_addr = 10'd2;
        tick();
        f_req = 1'b0;
        tick();
        d_req = 1'b0;
        rst = 1'b1;
        checks++;
        if (d_rvalid !== 1'b1 || d_rdata !== 32'h02200513) begin
            errors++;
            $display("FAIL rstmid_pre: drv %b drd %h, required 1 02200513", d_rvalid, d_rdata);
        end
        tick();
        rst = 1'b0;
        checks++;
        if (d_rvalid !== 1'b0 || starve_cnt !== 4'd0 || rom_addr !== 10'd0 || d_rdata !== 32'h0) begin
            errors++;
            $display("FAIL rstmid_post: drv %b cnt %0d ra %0d drd %h, required 0 0 0 0",
                     d_rvalid, starve_cnt, rom_addr, d_rdata);
        end
    endtask

    task automatic test_past_end();
        do_reset();
        d_req = 1'b1; d_addr = 10'd13;
        tick();
        d_addr = 10'd1000;
        tick();
        d_req = 1'b0;
        checks++;
        if (d_rvalid !== 1'b1 || d_rdata !== 32'h0) begin
            errors++;
            $display("FAIL past_end: drv %b drd %h, required 1 00000000", d_rvalid, d_rdata);
        end
        tick();
    endtask

    task automatic test_random();
        int          m_run;
        bit          m_force;
        logic        m_frv, m_drv;
        logic [31:0] m_frd, m_drd;
        logic [9:0]  m_ra;
        logic        e_fg, e_dg, pf, pd;
        logic [9:0]  e_ra;
        logic [3:0]  e_cnt;
        int          run_n;
        do_reset();
        m_run = 0; m_force = 1'b0; m_frv = 1'b0; m_drv = 1'b0;
        m_frd = '0; m_drd = '0; m_ra = '0; pf = 1'b0; pd = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (!f_req || pf) begin
                f_req = ($urandom_range(99) < 70);
                f_addr = 10'($urandom_range(31));
            end
            if (!d_req || pd) begin
                d_req = ($urandom_range(99) < 60);
                d_addr = 10'($urandom_range(31));
            end
            // Debug owed a slot gets it outright; otherwise fetch first.
            if (m_force) begin
                e_fg = 1'b0; e_dg = d_req; run_n = 0;
            end else begin
                e_fg = f_req; e_dg = d_req && !f_req;
                run_n = (f_req && d_req) ? m_run + 1 : 0;
                if (run_n > SM) run_n = SM;
            end
            e_ra  = e_fg ? f_addr : (e_dg ? d_addr : m_ra);
            e_cnt = 4'((m_run > SM - 1) ? SM - 1 : m_run);
            #2;
            checks++;
            if (f_gnt !== e_fg || d_gnt !== e_dg || rom_addr !== e_ra || starve_cnt !== e_cnt) begin
                errors++;
                $display("FAIL rnd_comb cyc %0d: fg %b dg %b ra %0d cnt %0d, required %b %b %0d %0d",
                         cyc, f_gnt, d_gnt, rom_addr, starve_cnt, e_fg, e_dg, e_ra, e_cnt);
            end
            m_force = !m_force && (run_n >= SM);
            m_run   = run_n;
            m_ra    = e_ra;
            m_frv   = e_fg;
            m_drv   = e_dg;
            if (e_fg) m_frd = rom_fn(f_addr);
            if (e_dg) m_drd = rom_fn(d_addr);
            pf = e_fg; pd = e_dg;
            tick();
            checks++;
            if (f_rvalid !== m_frv || d_rvalid !== m_drv || f_rdata !== m_frd || d_rdata !== m_drd) begin
                errors++;
                $display("FAIL rnd_data cyc %0d: frv %b drv %b frd %h drd %h, required %b %b %h %h",
                         cyc, f_rvalid, d_rvalid, f_rdata, d_rdata, m_frv, m_drv, m_frd, m_drd);
            end
        end
        f_req = 1'b0; d_req = 1'b0;
        tick();
    endtask

    initial begin
        rst = 1'b1; f_req = 1'b0; d_req = 1'b0; f_addr = '0; d_addr = '0;
        #1;
        test_reset();
        test_fetch_seq();
        test_debug_single();
        test_starvation();
        test_force_drop();
        test_reset_mid();
        test_past_end();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
